// File: rtl/sdram_ctl.sv
// Single-port SDRAM controller for the DE0 16-bit SDRAM (4 banks, 13-bit row, 10-bit column).
// Byte-wide req/ready port; every access is ACTIVE + READ/WRITE with auto-precharge.
module sdram_ctl #(
  parameter int unsigned INIT_WAIT      = 10000,
  parameter int unsigned REFRESH_PERIOD = 750,
  parameter int unsigned TRP            = 2,
  parameter int unsigned TRCD           = 2,
  parameter int unsigned TRFC           = 7,
  parameter int unsigned TWR            = 2,
  parameter int unsigned CL             = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [25:0] address,
  input  logic [7:0]  data,
  output logic [7:0]  q,
  output logic        ready,
  output logic        busy,
  output logic        init_done,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_addr,
  output logic        sd_ldqm,
  output logic        sd_udqm,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  input  logic [15:0] dq_i
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdDesel = 4'b1111;
  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdAct   = 4'b0011;
  localparam logic [3:0] CmdRd    = 4'b0101;
  localparam logic [3:0] CmdWr    = 4'b0100;
  localparam logic [3:0] CmdPre   = 4'b0010;
  localparam logic [3:0] CmdRef   = 4'b0001;
  localparam logic [3:0] CmdMrs   = 4'b0000;

  // Burst length 1, sequential, CAS latency in [6:4].
  localparam logic [12:0] ModeWord = (CL == 3) ? 13'h030 : 13'h020;
  // IDLE itself costs one cycle before the next ACTIVE, so REFRESH-to-ACTIVE is exactly TRFC.
  localparam int unsigned RefRet   = (TRFC > 1) ? TRFC - 2 : 0;

  typedef enum logic [3:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitMrs,
    StIdle, StRef, StRcd, StCas, StWdata, StRecov
  } state_e;

  state_e      state;
  logic [15:0] timer;
  logic [15:0] ref_cnt;
  logic        ref_pending;
  logic [3:0]  cmd;
  logic        op_we;
  logic [1:0]  op_bank;
  logic [9:0]  op_col;
  logic        op_lane;
  logic [7:0]  op_data;

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;
  assign busy = !((state == StIdle) && init_done);

  // Command sequencer, registered pin drivers and refresh timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StInitWait;
      timer       <= 16'(INIT_WAIT);
      ref_cnt     <= 16'(REFRESH_PERIOD - 1);
      ref_pending <= 1'b0;
      cmd         <= CmdDesel;
      sd_cke      <= 1'b1;
      sd_ba       <= 2'b00;
      sd_addr     <= 13'h0000;
      sd_ldqm     <= 1'b1;
      sd_udqm     <= 1'b1;
      dq_o        <= 16'h0000;
      dq_oe       <= 1'b0;
      ready       <= 1'b0;
      init_done   <= 1'b0;
      q           <= 8'h00;
      op_we       <= 1'b0;
      op_bank     <= 2'b00;
      op_col      <= 10'h000;
      op_lane     <= 1'b0;
      op_data     <= 8'h00;
    end else begin
      cmd    <= CmdNop;
      ready  <= 1'b0;
      dq_oe  <= 1'b0;
      sd_cke <= 1'b1;
      if (timer != 16'd0) timer <= timer - 16'd1;

      unique case (state)
        StInitWait: if (timer == 16'd0) begin
          cmd     <= CmdPre;
          sd_addr <= 13'h0400;  // A10: all banks
          state   <= StInitPre;
          timer   <= 16'(TRP - 1);
        end
        StInitPre: if (timer == 16'd0) begin
          cmd   <= CmdRef;
          state <= StInitRef1;
          timer <= 16'(TRFC - 1);
        end
        StInitRef1: if (timer == 16'd0) begin
          cmd   <= CmdRef;
          state <= StInitRef2;
          timer <= 16'(TRFC - 1);
        end
        StInitRef2: if (timer == 16'd0) begin
          cmd     <= CmdMrs;
          sd_ba   <= 2'b00;
          sd_addr <= ModeWord;
          state   <= StInitMrs;
          timer   <= 16'd1;
        end
        StInitMrs: if (timer == 16'd0) begin
          init_done <= 1'b1;
          state     <= StIdle;
        end
        StIdle: begin
          if (ref_pending) begin
            cmd         <= CmdRef;
            ref_pending <= 1'b0;
            state       <= StRef;
            timer       <= 16'(RefRet);
          end else if (req) begin
            op_we   <= we;
            op_bank <= address[25:24];
            op_col  <= address[10:1];
            op_lane <= address[0];
            op_data <= data;
            cmd     <= CmdAct;
            sd_ba   <= address[25:24];
            sd_addr <= address[23:11];
            sd_ldqm <= we ? address[0] : 1'b0;
            sd_udqm <= we ? ~address[0] : 1'b0;
            state   <= StRcd;
            timer   <= 16'(TRCD - 1);
          end
        end
        StRef: if (timer == 16'd0) state <= StIdle;
        StRcd: if (timer == 16'd0) begin
          sd_ba   <= op_bank;
          sd_addr <= {2'b00, 1'b1, op_col};  // A10: auto-precharge
          if (op_we) begin
            cmd   <= CmdWr;
            dq_oe <= 1'b1;
            dq_o  <= {op_data, op_data};
            state <= StWdata;
          end else begin
            cmd   <= CmdRd;
            state <= StCas;
            timer <= 16'(CL);
          end
        end
        StCas: if (timer == 16'd0) begin
          q       <= op_lane ? dq_i[15:8] : dq_i[7:0];
          ready   <= 1'b1;
          sd_ldqm <= 1'b1;
          sd_udqm <= 1'b1;
          state   <= StRecov;
          timer   <= 16'(TRP - 1);
        end
        StWdata: begin
          ready   <= 1'b1;
          sd_ldqm <= 1'b1;
          sd_udqm <= 1'b1;
          state   <= StRecov;
          timer   <= 16'(TWR + TRP - 1);
        end
        StRecov: if (timer == 16'd0) state <= StIdle;
        default: state <= StInitWait;
      endcase

      // Expiry wins over a same-cycle service in IDLE so no period is lost.
      if (!init_done) begin
        ref_cnt <= 16'(REFRESH_PERIOD - 1);
      end else if (ref_cnt == 16'd0) begin
        ref_cnt     <= 16'(REFRESH_PERIOD - 1);
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_ctl.sv
// Directed bench for sdram_ctl with a small behavioural SDRAM model.
module tb_sdram_ctl;

  localparam int unsigned InitW = 20;
  localparam int unsigned RefP  = 50;
  localparam int unsigned Trp   = 2;
  localparam int unsigned Trcd  = 2;
  localparam int unsigned Trfc  = 7;
  localparam int unsigned Twr   = 2;
  localparam int unsigned Cl    = 2;
  localparam int unsigned MinActGap = Trcd + Cl + Trp + 2;

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [25:0] address = '0;
  logic [7:0]  data = '0;
  logic [7:0]  q;
  logic        ready, busy, init_done;
  logic        sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic        sd_ldqm, sd_udqm;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [15:0] dq_i = 16'hBEEF;
  logic [3:0]  cmd;

  always #5 clock = ~clock;

  sdram_ctl #(
    .INIT_WAIT(InitW), .REFRESH_PERIOD(RefP), .TRP(Trp), .TRCD(Trcd),
    .TRFC(Trfc), .TWR(Twr), .CL(Cl)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .address(address), .data(data),
    .q(q), .ready(ready), .busy(busy), .init_done(init_done),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n),
    .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_ldqm(sd_ldqm),
    .sd_udqm(sd_udqm), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
  );

  assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pin monitor and SDRAM model state.
  int          cyc = 0;
  int          act_cnt = 0, rdy_cnt = 0;
  int          act_cyc = 0, rd_cyc = 0, wr_cyc = 0, rdy_cyc = 0;
  logic [1:0]  act_ba, rd_ba;
  logic [12:0] act_addr, rd_addr, wr_addr;
  logic        rd_ldqm, rd_udqm, wr_ldqm, wr_udqm, wr_oe;
  logic [15:0] wr_dq, rd_word;
  logic        prev_ready = 1'b0;
  int          rd_cnt = 0;
  logic [12:0] open_row [0:3];
  logic [15:0] mem [logic [24:0]];
  logic [24:0] key;
  logic [15:0] word;

  always @(negedge clock) begin
    cyc++;
    dq_i = 16'hBEEF;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) dq_i = rd_word;
    end
    if (ready) begin
      check_eq("ready_consecutive", prev_ready, 1'b0);
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    prev_ready = ready;
    if (dq_oe) check_eq("oe_only_on_write", cmd, CmdWr);
    case (cmd)
      CmdAct: begin
        if (act_cnt > 0) check_eq("act_gap", (cyc - act_cyc) >= int'(MinActGap), 1'b1);
        act_cnt++;
        act_cyc  = cyc;
        act_ba   = sd_ba;
        act_addr = sd_addr;
        open_row[sd_ba] = sd_addr;
      end
      CmdRd: begin
        rd_cyc  = cyc;
        rd_ba   = sd_ba;
        rd_addr = sd_addr;
        rd_ldqm = sd_ldqm;
        rd_udqm = sd_udqm;
        key     = {sd_ba, open_row[sd_ba], sd_addr[9:0]};
        rd_word = mem.exists(key) ? mem[key] : 16'h0000;
        rd_cnt  = Cl;
      end
      CmdWr: begin
        wr_cyc  = cyc;
        wr_addr = sd_addr;
        wr_ldqm = sd_ldqm;
        wr_udqm = sd_udqm;
        wr_dq   = dq_o;
        wr_oe   = dq_oe;
        key     = {sd_ba, open_row[sd_ba], sd_addr[9:0]};
        word    = mem.exists(key) ? mem[key] : 16'h0000;
        if (!sd_ldqm) word[7:0] = dq_o[7:0];
        if (!sd_udqm) word[15:8] = dq_o[15:8];
        mem[key] = word;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    req   = 1'b0;
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Follows the power-up sequence; returns on the cycle init_done is first seen high.
  task automatic check_init();
    int nops = 0;
    int stage = 0;
    int t_pre = 0, t_r1 = 0, t_r2 = 0, t_mrs = 0;
    for (int i = 0; i < 300 && stage < 5; i++) begin
      tick();
      if (stage == 4) begin
        if (init_done) begin
          check_eq("init_done_delay", i - t_mrs, 2);
          check_eq("init_idle_busy", busy, 1'b0);
          stage = 5;
        end else if (cmd != CmdNop) begin
          check_eq("init_extra_cmd", cmd, CmdNop);
        end
      end else if (cmd == CmdNop) begin
        if (stage == 0) nops++;
      end else begin
        case (stage)
          0: begin
            check_eq("init_nop_count", nops, InitW);
            check_eq("init_pre_cmd", cmd, CmdPre);
            check_eq("init_pre_a10", sd_addr[10], 1'b1);
            t_pre = i;
          end
          1: begin
            check_eq("init_ref1_cmd", cmd, CmdRef);
            check_eq("init_trp", i - t_pre, Trp);
            t_r1 = i;
          end
          2: begin
            check_eq("init_ref2_cmd", cmd, CmdRef);
            check_eq("init_trfc", i - t_r1, Trfc);
            t_r2 = i;
          end
          default: begin
            check_eq("init_mrs_cmd", cmd, CmdMrs);
            check_eq("init_mrs_gap", i - t_r2, Trfc);
            check_eq("init_mode_word", sd_addr, 13'h020);
            check_eq("init_done_early", init_done, 1'b0);
            t_mrs = i;
          end
        endcase
        stage++;
      end
    end
    check_eq("init_complete", stage, 5);
  endtask

  task automatic access(input logic w, input logic [25:0] a, input logic [7:0] d,
                        input bit scramble);
    int a0 = act_cnt;
    bit ok = 1'b0;
    we = w; address = a; data = d; req = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (ready) ok = 1'b1;
      else if (scramble && act_cnt != a0) begin
        we = ~w; address = ~a; data = ~d;
      end
    end
    req = 1'b0;
    check_eq("access_ready", ok, 1'b1);
    check_eq("busy_on_ready", busy, 1'b1);
    if (w) check_eq("wr_latency", rdy_cyc - act_cyc, 1 + Trcd);
    else   check_eq("rd_latency", rdy_cyc - act_cyc, 1 + Trcd + Cl);
  endtask

  initial begin
    int stage, t, r0, a0, n;
    bit got_rdy, seen;

    // Reset state.
    do_reset(3);
    check_eq("rst_cmd", cmd, 4'b1111);
    check_eq("rst_misc", {sd_cke, sd_ldqm, sd_udqm, dq_oe, ready, busy, init_done},
             7'b1110010);
    check_eq("rst_addr", {sd_ba, sd_addr}, 15'h0000);
    check_eq("rst_dq_q", {dq_o, q}, 24'h000000);

    check_init();

    // Request lands on the cycle the first refresh expiry is pending.
    repeat (RefP) tick();
    we = 1'b0; address = 26'h0000001; req = 1'b1;
    stage = 0; t = 0; got_rdy = 1'b0; r0 = rdy_cnt;
    for (int i = 0; i < 100 && !got_rdy; i++) begin
      tick();
      if (ready) got_rdy = 1'b1;
      else if (cmd != CmdNop) begin
        if (stage == 0) begin
          check_eq("ref_first", cmd, CmdRef);
          t = i;
        end else if (stage == 1) begin
          check_eq("ref_then_act", cmd, CmdAct);
          check_eq("ref_act_gap", i - t, Trfc);
        end
        stage++;
      end
    end
    req = 1'b0;
    check_eq("ref_ready", got_rdy, 1'b1);
    check_eq("ref_q_blank", q, 8'h00);
    repeat (20) tick();
    check_eq("ref_one_ready", rdy_cnt - r0, 1);

    // Upper-lane write, then read back.
    access(1'b1, 26'h0000001, 8'h5A, 1'b0);
    check_eq("wr1_ldqm", wr_ldqm, 1'b1);
    check_eq("wr1_udqm", wr_udqm, 1'b0);
    check_eq("wr1_dq", wr_dq, 16'h5A5A);
    check_eq("wr1_oe", wr_oe, 1'b1);
    check_eq("wr1_a10_col", wr_addr[10:0], 11'h400);
    check_eq("wr1_trcd", wr_cyc - act_cyc, Trcd);
    access(1'b0, 26'h0000001, 8'h00, 1'b0);
    check_eq("rd1_q", q, 8'h5A);
    check_eq("rd1_word", rd_word, 16'h5A00);
    check_eq("rd1_a10_col", rd_addr[10:0], 11'h400);
    check_eq("rd1_trcd", rd_cyc - act_cyc, Trcd);
    check_eq("rd1_dqm", {rd_ldqm, rd_udqm}, 2'b00);

    // Lower-lane write, then read both lanes.
    access(1'b1, 26'h0000000, 8'hC3, 1'b0);
    check_eq("wr0_ldqm", wr_ldqm, 1'b0);
    check_eq("wr0_udqm", wr_udqm, 1'b1);
    check_eq("wr0_dq", wr_dq, 16'hC3C3);
    access(1'b0, 26'h0000000, 8'h00, 1'b0);
    check_eq("rd0_q", q, 8'hC3);
    check_eq("rd0_word", rd_word, 16'h5AC3);
    access(1'b0, 26'h0000001, 8'h00, 1'b0);
    check_eq("rd1b_q", q, 8'h5A);

    // Top address; inputs scrambled after acceptance must be ignored.
    access(1'b1, 26'h3FFFFFF, 8'h77, 1'b1);
    check_eq("top_wr_ba", act_ba, 2'd3);
    check_eq("top_wr_row", act_addr, 13'h1FFF);
    check_eq("top_wr_col", wr_addr[10:0], 11'h7FF);
    check_eq("top_wr_dq", wr_dq, 16'h7777);
    access(1'b0, 26'h3FFFFFF, 8'h00, 1'b1);
    check_eq("top_rd_ba", {act_ba, rd_ba}, 4'hF);
    check_eq("top_rd_row", act_addr, 13'h1FFF);
    check_eq("top_rd_col", rd_addr[10:0], 11'h7FF);
    check_eq("top_rd_q", q, 8'h77);
    repeat (5) tick();
    check_eq("q_hold", q, 8'h77);

    // Back-to-back reads with req held.
    r0 = rdy_cnt; a0 = act_cnt; n = 0;
    we = 1'b0; address = 26'h0000001; req = 1'b1;
    for (int i = 0; i < 400 && n < 3; i++) begin
      tick();
      if (ready) begin
        n++;
        check_eq("b2b_q", q, 8'h5A);
      end
    end
    req = 1'b0;
    repeat (15) tick();
    check_eq("b2b_readys", rdy_cnt - r0, 3);
    check_eq("b2b_acts", act_cnt - a0, 3);

    // Reset one cycle after READ: access aborted, full init again.
    we = 1'b0; address = 26'h0000000; req = 1'b1; seen = 1'b0; r0 = rdy_cnt;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (cmd == CmdRd) seen = 1'b1;
    end
    check_eq("abort_read_seen", seen, 1'b1);
    tick();
    do_reset(1);
    check_eq("abort_ready", ready, 1'b0);
    check_eq("abort_init_done", init_done, 1'b0);
    check_eq("abort_busy", busy, 1'b1);
    check_init();
    check_eq("abort_no_ready", rdy_cnt - r0, 0);
    access(1'b0, 26'h0000000, 8'h00, 1'b0);
    check_eq("after_abort_q", q, 8'hC3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_ctl.md
Name: sdram_ctl

Overview:
- Single-port controller for the DE0 board SDRAM: 16-bit, 4 banks, 13-bit row, 10-bit column.
- Presents a byte-wide, request/ready memory port to the core88 memory router. It replaces the 256 KB on-chip `memory` block when address space beyond on-chip RAM is needed.
- Sequences power-up init, periodic auto-refresh and single-byte reads and writes.
- Runs on `clock_100`. All DRAM pin outputs are registered. The top level drives `DRAM_CLK` and ties `dq_o`/`dq_oe` to the tristate `DRAM_DQ`.

Parameters:
- INIT_WAIT, 10000: cycles of NOP after reset before the first PRECHARGE (100 µs at 100 MHz).
- REFRESH_PERIOD, 750: cycles between refresh requests.
- TRP, 2: precharge-to-command cycles (minimum 1).
- TRCD, 2: ACTIVE-to-READ/WRITE cycles.
- TRFC, 7: REFRESH-to-command cycles.
- TWR, 2: last write data to precharge-complete cycles.
- CL, 2: CAS latency. Only 2 or 3 are legal.

Ports:
- clock  in  1  controller clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request. Held high until `ready`.
- we  in  1  1 = write, 0 = read. Sampled with `req`.
- address  in  26  byte address.
- data  in  8  write byte.
- q  out  8  read byte. Valid when `ready` = 1 on a read; holds its value otherwise.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  1 whenever the controller is not in IDLE.
- init_done  out  1  1 after the mode-register load; stays 1 until the next reset.
- sd_cke  out  1  DRAM_CKE.
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  command pins.
- sd_ba  out  2  bank address.
- sd_addr  out  13  row/column/mode address.
- sd_ldqm, sd_udqm  out  1 each  byte masks.
- dq_o  out  16  write data.
- dq_oe  out  1  DQ output enable.
- dq_i  in  16  read data from DRAM_DQ.

Behaviour:
- Reset:
  - Synchronous, active-high; takes effect at any point, including mid-access. No `ready` is issued for an aborted access.
  - Goes to INIT_WAIT. Outputs: cs_n=1, ras_n=cas_n=we_n=1, cke=1, ba=0, sd_addr=0, ldqm=udqm=1, dq_oe=0, dq_o=0, ready=0, busy=1, init_done=0, q=0.
  - The refresh counter and pending flag are cleared.
- Command encodings (cs_n, ras_n, cas_n, we_n):
  - NOP = 0111
  - ACTIVE = 0011
  - READ = 0101
  - WRITE = 0100
  - PRECHARGE = 0010
  - REFRESH = 0001
  - LOAD MODE = 0000
  - NOP is driven on every cycle not listed below.
- Address map:
  - address[0] selects the byte lane.
  - address[10:1] = column.
  - address[23:11] = row.
  - address[25:24] = bank.
  - The full address is latched at acceptance.
- Init sequence:
  - INIT_WAIT: INIT_WAIT cycles of NOP.
  - PRECHARGE all (sd_addr[10]=1), then TRP cycles of wait.
  - REFRESH, TRFC wait; then a second REFRESH, TRFC wait.
  - LOAD MODE with sd_addr = 13'h020 (burst 1, sequential, CL) or 13'h030 (CL=3).
  - Then 2 NOP cycles, after which init_done=1 and the state goes to IDLE.
  - `req` is ignored until init_done=1.
- Refresh:
  - A down-counter reloads to REFRESH_PERIOD-1. On reaching 0 it sets refresh_pending, starting only once init_done=1.
  - In IDLE, refresh_pending takes priority over `req`. Issue REFRESH, clear pending, wait TRFC, return to IDLE.
  - An expiry during an access sets pending. The refresh is serviced at the next IDLE.
- Read path:
  - `req` is accepted in IDLE at edge 0.
  - ACTIVE is on the pins at cycle 1.
  - READ with auto-precharge (sd_addr[10]=1, column in [9:0]) is at cycle 1+TRCD.
  - dq_i is sampled at cycle 1+TRCD+CL.
  - q = dq_i[7:0] if address[0]=0, else dq_i[15:8]. It is registered with ready=1 at cycle 2+TRCD+CL.
  - Then TRP cycles of wait, then IDLE.
  - ldqm=udqm=0 from ACTIVE through data sampling.
- Write path:
  - ACTIVE at cycle 1.
  - WRITE with auto-precharge at cycle 1+TRCD, with dq_oe=1 and dq_o={data,data} for that cycle only.
  - Byte masks: ldqm=address[0], udqm=~address[0].
  - ready=1 at cycle 2+TRCD.
  - Then a TWR+TRP wait, then IDLE.
- Handshake:
  - `ready` is a single-cycle pulse per accepted request.
  - At least one non-IDLE cycle follows `ready`, so a requester that drops `req` on the cycle after `ready` is never re-accepted.
  - `we`/`address`/`data` changes after acceptance are ignored.
- busy = 0 only in IDLE with init_done=1.

Test Plan:
- INIT_WAIT=20; release reset → 20 NOP cycles, then PRECHARGE with sd_addr[10]=1, 2 REFRESH commands TRFC apart, then LOAD MODE with sd_addr=13'h020; init_done rises exactly 2 cycles after LOAD MODE.
- Write 8'h5A to 26'h0000001, then read 26'h0000001 → WRITE has ldqm=1, udqm=0, dq_o=16'h5A5A; the DRAM model returns 16'h5A00; q=8'h5A with ready at cycle 2+TRCD+CL. Repeat at 26'h0000000 with 8'hC3 → ldqm=0, udqm=1.
- Address 26'h3FFFFFF → ACTIVE with ba=3, sd_addr=13'h1FFF; READ with sd_addr[9:0]=10'h3FF, sd_addr[10]=1.
- REFRESH_PERIOD=50; hold `req` high so the request coincides with counter expiry in IDLE → REFRESH issued first; ACTIVE follows TRFC cycles later; exactly one `ready`.
- Assert reset 1 cycle after READ is issued → no `ready`; init_done=0; the full init sequence repeats; a subsequent read returns the correct byte.
- Back-to-back requests with `req` held → at most one ACTIVE per `ready`; consecutive ACTIVEs are at least TRCD+CL+TRP+2 cycles apart; `ready` never occurs on two consecutive cycles.
